// File: rtl/compressed_fetch_buffer.sv
// Prefetch queue ahead of the decompressor: fetches sequential 32-bit words from
// compressed instruction memory into a small FIFO and restarts on redirect.
module compressed_fetch_buffer #(
  parameter int unsigned      WIDTH = 32,
  parameter int unsigned      DEPTH = 4,
  parameter logic [WIDTH-1:0] PCADD = WIDTH'(32'h4)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [WIDTH-1:0] PCcompress,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             instr_valid,
  output logic [WIDTH-1:0] NextInstr,
  input  logic             instr_take
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic               push;
  logic               pop;
  logic               has_room;

  // State register and fetch bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage is never read while empty, so it carries no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= mem_rdata;
    end
  end

  // FIFO pointer/count update; redirect clears and suppresses push and pop
  always_comb begin
    push    = (state_q == WAIT) && mem_rvalid && !redirect;
    pop     = instr_take && (count_q != '0) && !redirect;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (redirect) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    has_room = count_d < CNT_W'(DEPTH);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = PCcompress;
    end else if ((state_q == REQ) && mem_gnt) begin
      fetch_pc_d = fetch_pc_q + PCADD;
    end
  end

  // Next-state logic; slot is guaranteed before entering REQ
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (has_room) state_d = REQ;
      REQ:     if (mem_gnt) state_d = WAIT;
      WAIT:    if (mem_rvalid) state_d = has_room ? REQ : IDLE;
      DRAIN:   if (mem_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      // A response landing together with the redirect retires the outstanding request
      if (((state_q == WAIT) && !mem_rvalid) ||
          ((state_q == REQ) && mem_gnt) ||
          ((state_q == DRAIN) && !mem_rvalid)) begin
        state_d = DRAIN;
      end else begin
        state_d = REQ;
      end
    end
  end

  // Outputs decode from registered state only
  always_comb begin
    mem_req     = (state_q == REQ);
    mem_addr    = fetch_pc_q;
    instr_valid = (count_q != '0);
    NextInstr   = '0;
    if (count_q != '0) begin
      NextInstr = mem_q[rptr_q];
    end
  end

endmodule

// File: doc/compressed_fetch_buffer.md
# compressed_fetch_buffer

Prefetch stage directly upstream of the decompressor. Fetches 32-bit words from compressed instruction memory at a sequential fetch address and queues them in a small FIFO. Presents the queue head as `NextInstr` with a valid/take handshake. A redirect from the decompressor's branch logic flushes the queue, discards any in-flight response and restarts fetching at the new compressed PC.

## Interface
- `WIDTH`, 32, data and address width
- `DEPTH`, 4, FIFO entries (power of two, ≥2)
- `PCADD`, 32'h4, fetch address increment per word
- `clk` input 1: rising-edge clock
- `reset` input 1: asynchronous, active-low reset (asserted when 0)
- `redirect` input 1: flush and restart fetch at `PCcompress`
- `PCcompress` input WIDTH: new fetch address, sampled when `redirect`=1
- `mem_req` output 1: memory read request
- `mem_addr` output WIDTH: request address, stable while `mem_req`=1
- `mem_gnt` input 1: request accepted this cycle
- `mem_rvalid` input 1: read data valid
- `mem_rdata` input WIDTH: read data
- `instr_valid` output 1: FIFO non-empty
- `NextInstr` output WIDTH: FIFO head word, 0 when empty
- `instr_take` input 1: consumer pops head (ignored when `instr_valid`=0)

## Operation
- Registers: `fetch_pc` (WIDTH), FIFO storage (DEPTH×WIDTH), read/write pointers (log2 DEPTH bits, wrapping), `count` (log2 DEPTH + 1 bits), FSM state.
- At most one outstanding memory request.
- FSM states:
  - IDLE: `mem_req`=0. Go to REQ when `count` < DEPTH.
  - REQ: `mem_req`=1, `mem_addr`=`fetch_pc`. On `mem_gnt`: `fetch_pc` += PCADD (mod 2^WIDTH), go to WAIT.
  - WAIT: on `mem_rvalid`, push `mem_rdata`.
    - Next state is REQ if post-push `count` < DEPTH, else IDLE.
    - The slot is reserved at grant, so a push never overflows.
  - DRAIN: outstanding response is discarded. On `mem_rvalid`, drop the data and go to REQ.
- Issue condition: REQ is entered only if `count` + (pops this cycle) leaves a free slot. A grant is never given a request without a guaranteed slot.
- Redirect has priority over all other events:
  - FIFO cleared (`count`=0, pointers=0).
  - `fetch_pc` ← `PCcompress`.
  - Next state: from WAIT (with no `mem_rvalid` this cycle) or from REQ-with-grant, go to DRAIN. Otherwise go to REQ.
  - A response in the same cycle as redirect is dropped.
  - A pop in the same cycle as redirect is ignored.
- A redirect during DRAIN updates `fetch_pc` and stays in DRAIN.
- Simultaneous push and pop: `count` unchanged, both pointers advance.
- Pointers wrap DEPTH-1 → 0.

## Timing
- Reset (`reset`=0, async) values:
  - Outputs: `mem_req`=0, `mem_addr`=0, `instr_valid`=0, `NextInstr`=0.
  - Internal: `fetch_pc`=0, `count`=0, state IDLE.
- First cycle after reset release: IDLE → REQ, so `mem_req`=1 at address 0 on the second edge.
- Latency: data pushed on a `mem_rvalid` edge appears on `NextInstr` with `instr_valid`=1 in the following cycle.
- `NextInstr` and `instr_valid` are combinational from FIFO state only, with no path from `instr_take`.
- Throughput with single-cycle grant and response: one word per 2 cycles (REQ, WAIT).
- Redirect seen at edge N: `instr_valid`=0 from N+1.
  - With no outstanding request, `mem_req`=1 with `mem_addr`=`PCcompress` from N+1.

## Test plan
- Reset and stream:
  - Stimulus: hold `reset`=0, then release; memory grants immediately and returns `mem_rdata`=addr^32'hF000_0000 one cycle later.
  - Required: outputs 0 during reset. Requests to 0x0, 0x4, 0x8. `NextInstr` sequence F000_0000, F000_0004, F000_0008 with `instr_take`=1.
- Full/backpressure:
  - Stimulus: `instr_take`=0 throughout.
  - Required: exactly 4 requests (0x0–0xC), then `mem_req` stays 0 with `count`=4.
  - Then one take: exactly one new request, to 0x10.
- Redirect while waiting:
  - Stimulus: grant at 0x8, then `redirect`=1 with `PCcompress`=0x100 before `mem_rvalid`; the late response carries data 0xDEAD_BEEF.
  - Required: 0xDEAD_BEEF never appears on `NextInstr`. The next request is 0x100.
- Redirect with simultaneous response and pop:
  - Stimulus: `redirect`, `mem_rvalid` and `instr_take` all in one cycle.
  - Required: FIFO empty next cycle. Next request is to the new PC.
- Pointer wrap:
  - Stimulus: stream 12 words with random `instr_take` and random 0–3 cycle grant/response delays.
  - Required: output order matches address order, with no loss or duplication.
- Async reset mid-operation:
  - Stimulus: drop `reset` between clock edges while in WAIT with 2 words queued.
  - Required: all outputs 0 immediately, without waiting for a clock edge. Restart at address 0 after release.
